blk_oe_sequencer: RTL and testbench

- Readout sequencer directly upstream of the block multiplexer.
- On each block request it generates the START, OE_B, DLOAD and OECRC strobe pattern that steps the multiplexer through 6 ADC channels for NSAMP sample rows, then through the CRC/status trailer.
- It then waits for the multiplexer's end-of-block clear (clr_oec), which also serves as this block's reset.
- A timeout covers the case where the clear never arrives.

---
 rtl/blk_oe_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_blk_oe_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_oe_sequencer.sv
// ============================================================================
// blk_oe_sequencer
//
// Readout sequencer that sits directly in front of the block multiplexer.
// Each rising edge of GO starts one block. A block is:
//   ARM      1 cycle         START pulse, which arms the downstream CRC
//   ROW      6*NSAMP cycles  one-hot active-low channel strobe per row, or a
//                            raw pass-through (DLOAD) for rows flagged by BCODE
//   TRAIL    TRAIL cycles    idle slots for the CRC/status trailer words
//   WAIT_CLR up to TMO       waits for the multiplexer's end-of-block clear
// If the clear does not arrive within TMO cycles, the block gives up, sets
// the sticky ERR_TMO flag and returns to IDLE on its own.
//
// Every output is a flop. The output flops are loaded from a decode of the
// *next* state, so each strobe lines up with the state it belongs to without
// a combinational path from any input to any output.
//
// Ports
//   CLK25    in   25 MHz readout clock, rising edge
//   clr_oec  in   asynchronous active-high clear (RST | end-of-block)
//   GO       in   block request level; a rising edge starts a block
//   BCODE    in   captured when a row starts; 1 = raw "B code" row
//   START    out  one-cycle CRC-arm pulse
//   OE_B     out  [5:0] active-low one-hot channel strobe, bit n = channel n
//   DLOAD    out  raw-data pass-through select
//   OECRC    out  high for the six cycles of the last row
//   BUSY     out  high whenever the sequencer is not idle
//   ERR_TMO  out  sticky: the end-of-block clear timed out
//   GO_OVR   out  sticky: a GO rising edge arrived while busy
// ============================================================================
module blk_oe_sequencer #(
    parameter int NSAMP = 8,   // sample rows per block, 1..255
    parameter int TRAIL = 4,   // trailer idle cycles after the last row
    parameter int TMO   = 64   // cycles allowed in WAIT_CLR, >= 2
) (
    input  logic       CLK25,
    input  logic       clr_oec,
    input  logic       GO,
    input  logic       BCODE,
    output logic       START,
    output logic [5:0] OE_B,
    output logic       DLOAD,
    output logic       OECRC,
    output logic       BUSY,
    output logic       ERR_TMO,
    output logic       GO_OVR
);

    // ------------------------------------------------------------------------
    // Counter sizing
    // ------------------------------------------------------------------------
    localparam int TMAX = (TRAIL > TMO) ? TRAIL : TMO;
    localparam int TCW  = $clog2(TMAX) + 1;

    localparam logic [7:0]     LAST_ROW   = 8'(NSAMP - 1);
    localparam logic [TCW-1:0] TRAIL_LAST = TCW'((TRAIL > 0) ? TRAIL - 1 : 0);
    localparam logic [TCW-1:0] TMO_LAST   = TCW'(TMO - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        ROW      = 3'd2,
        TRAILER  = 3'd3,
        WAIT_CLR = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------------
    state_t         state_reg, state_next;
    logic [7:0]     row_reg,   row_next;
    logic [2:0]     chan_reg,  chan_next;
    logic [TCW-1:0] tcnt_reg,  tcnt_next;
    logic           bc_reg,    bc_next;
    logic           go_1_reg;
    logic           go_edge;

    // Output flops and their next values
    logic       start_reg,   start_next;
    logic [5:0] oe_b_reg,    oe_b_next;
    logic       dload_reg,   dload_next;
    logic       oecrc_reg,   oecrc_next;
    logic       busy_reg,    busy_next;
    logic       err_tmo_reg, err_tmo_next;
    logic       go_ovr_reg,  go_ovr_next;

    // Row decode of the next state, shared by the strobe generators
    logic in_row_next;
    logic strobe_en_next;

    assign go_edge = GO & ~go_1_reg;

    // ------------------------------------------------------------------------
    // Sequential part. clr_oec doubles as the end-of-block acknowledge, so it
    // must pull every strobe back to idle within the same cycle: all flops,
    // outputs included, reset asynchronously.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK25 or posedge clr_oec) begin
        if (clr_oec) begin
            state_reg   <= IDLE;
            row_reg     <= '0;
            chan_reg    <= 3'd1;
            tcnt_reg    <= '0;
            bc_reg      <= 1'b0;
            go_1_reg    <= 1'b0;
            start_reg   <= 1'b0;
            oe_b_reg    <= 6'h3F;
            dload_reg   <= 1'b0;
            oecrc_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            err_tmo_reg <= 1'b0;
            go_ovr_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            row_reg     <= row_next;
            chan_reg    <= chan_next;
            tcnt_reg    <= tcnt_next;
            bc_reg      <= bc_next;
            go_1_reg    <= GO;
            start_reg   <= start_next;
            oe_b_reg    <= oe_b_next;
            dload_reg   <= dload_next;
            oecrc_reg   <= oecrc_next;
            busy_reg    <= busy_next;
            err_tmo_reg <= err_tmo_next;
            go_ovr_reg  <= go_ovr_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        row_next     = row_reg;
        chan_next    = chan_reg;
        tcnt_next    = tcnt_reg;
        bc_next      = bc_reg;
        err_tmo_next = err_tmo_reg;
        go_ovr_next  = go_ovr_reg;

        // A request edge is only honoured from IDLE; anywhere else it is
        // recorded as an overrun and otherwise ignored.
        if (go_edge && (state_reg != IDLE)) begin
            go_ovr_next = 1'b1;
        end

        unique case (state_reg)
            IDLE: begin
                if (go_edge) begin
                    state_next = ARM;
                end
            end

            ARM: begin
                state_next = ROW;
                row_next   = '0;
                chan_next  = 3'd1;
                bc_next    = BCODE;
            end

            ROW: begin
                if (chan_reg == 3'd6) begin
                    if (row_reg == LAST_ROW) begin
                        tcnt_next  = '0;
                        state_next = (TRAIL == 0) ? WAIT_CLR : TRAILER;
                    end else begin
                        row_next  = row_reg + 8'd1;
                        chan_next = 3'd1;
                        bc_next   = BCODE;
                    end
                end else if (chan_reg >= 3'd1 && chan_reg <= 3'd5) begin
                    chan_next = chan_reg + 3'd1;
                end else begin
                    // chan 0 and 7 cannot occur in normal operation; treat a
                    // corrupted channel counter as a lost block.
                    state_next = IDLE;
                    chan_next  = 3'd1;
                end
            end

            TRAILER: begin
                if (tcnt_reg == TRAIL_LAST) begin
                    tcnt_next  = '0;
                    state_next = WAIT_CLR;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end

            WAIT_CLR: begin
                // Normal exit is the asynchronous clear; reaching the last
                // count means the multiplexer never acknowledged the block.
                if (tcnt_reg == TMO_LAST) begin
                    err_tmo_next = 1'b1;
                    tcnt_next    = '0;
                    state_next   = IDLE;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state. Since the flops load these values on
    // the same edge that the state register moves, each strobe is valid for
    // exactly the cycles its state is occupied.
    // ------------------------------------------------------------------------
    always_comb begin
        in_row_next    = (state_next == ROW) &&
                         (chan_next >= 3'd1) && (chan_next <= 3'd6);
        strobe_en_next = in_row_next && !bc_next;
        start_next     = (state_next == ARM);
        dload_next     = in_row_next && bc_next;
        // The last row is the only one carrying the CRC marker; ARM never
        // satisfies in_row_next, so START and OECRC cannot overlap.
        oecrc_next     = in_row_next && (row_next == LAST_ROW);
        busy_next      = (state_next != IDLE);
    end

    // One active-low strobe per ADC channel; chan counts 1..6 for bits 0..5.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_oe_b
            assign oe_b_next[gi] = ~(strobe_en_next && (chan_next == 3'(gi + 1)));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Ports
    // ------------------------------------------------------------------------
    assign START   = start_reg;
    assign OE_B    = oe_b_reg;
    assign DLOAD   = dload_reg;
    assign OECRC   = oecrc_reg;
    assign BUSY    = busy_reg;
    assign ERR_TMO = err_tmo_reg;
    assign GO_OVR  = go_ovr_reg;

endmodule

// File: tb/tb_blk_oe_sequencer.sv
// ============================================================================
// tb_blk_oe_sequencer
//
// Two sequencers share the stimulus: one with NSAMP=8 and one with NSAMP=1.
// The reference model describes each block only by its position in time:
// an offset from the ARM cycle, from which row, channel, trailer and wait
// phases follow by division. Rows flagged as B-code are remembered in an
// array as the model sees BCODE when each row begins.
// ============================================================================
module tb_blk_oe_sequencer;

    localparam int TRAIL = 4;
    localparam int TMO   = 64;

    logic       CLK25 = 1'b0;
    logic       clr_oec;
    logic       GO;
    logic       BCODE;

    logic       START0, DLOAD0, OECRC0, BUSY0, ERR0, OVR0;
    logic [5:0] OE_B0;
    logic       START1, DLOAD1, OECRC1, BUSY1, ERR1, OVR1;
    logic [5:0] OE_B1;

    logic [11:0] obs0, obs1;
    assign obs0 = {START0, OE_B0, DLOAD0, OECRC0, BUSY0, ERR0, OVR0};
    assign obs1 = {START1, OE_B1, DLOAD1, OECRC1, BUSY1, ERR1, OVR1};

    blk_oe_sequencer #(.NSAMP(8), .TRAIL(TRAIL), .TMO(TMO)) dut (
        .CLK25(CLK25), .clr_oec(clr_oec), .GO(GO), .BCODE(BCODE),
        .START(START0), .OE_B(OE_B0), .DLOAD(DLOAD0), .OECRC(OECRC0),
        .BUSY(BUSY0), .ERR_TMO(ERR0), .GO_OVR(OVR0)
    );

    blk_oe_sequencer #(.NSAMP(1), .TRAIL(TRAIL), .TMO(TMO)) dut1 (
        .CLK25(CLK25), .clr_oec(clr_oec), .GO(GO), .BCODE(BCODE),
        .START(START1), .OE_B(OE_B1), .DLOAD(DLOAD1), .OECRC(OECRC1),
        .BUSY(BUSY1), .ERR_TMO(ERR1), .GO_OVR(OVR1)
    );

    always #20 CLK25 = ~CLK25;

    int checks = 0;
    int passes = 0;

    // ------------------------------------------------------------------------
    // Reference model: offset from ARM (-1 = idle), sticky flags, B-code rows
    // ------------------------------------------------------------------------
    int  mn [2];
    int  mo [2];
    bit  merr [2];
    bit  movr [2];
    bit  mbc [2][256];
    bit  mgo1;

    function automatic logic [11:0] exp_vec(input int k);
        int o, n, r, c;
        logic [5:0] oe;
        logic dl, oc;
        o = mo[k]; n = mn[k]; oe = 6'h3F; dl = 1'b0; oc = 1'b0;
        if (o >= 1 && o <= 6 * n) begin
            r = (o - 1) / 6;
            c = (o - 1) % 6;
            if (mbc[k][r]) dl = 1'b1;
            else oe[c] = 1'b0;
            oc = (r == n - 1);
        end
        return {o == 0, oe, dl, oc, o >= 0, merr[k], movr[k]};
    endfunction

    task automatic model_step();
        bit ge;
        ge = GO && !mgo1;
        for (int k = 0; k < 2; k++) begin
            int w;
            w = 1 + 6 * mn[k] + TRAIL;
            if (clr_oec) begin
                mo[k] = -1; merr[k] = 1'b0; movr[k] = 1'b0;
            end else begin
                if (mo[k] < 0) begin
                    if (ge) mo[k] = 0;
                end else begin
                    if (ge) movr[k] = 1'b1;
                    mo[k]++;
                    if (mo[k] == w + TMO) begin
                        mo[k] = -1;
                        merr[k] = 1'b1;
                    end
                end
                if (mo[k] >= 1 && mo[k] <= 6 * mn[k] && (mo[k] - 1) % 6 == 0)
                    mbc[k][(mo[k] - 1) / 6] = BCODE;
            end
        end
        mgo1 = clr_oec ? 1'b0 : GO;
    endtask

    // One clock: the model advances with the DUT edge, outputs are then
    // observed on the falling edge.
    task automatic tick();
        @(posedge CLK25);
        model_step();
        @(negedge CLK25);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        clr_oec = 1'b1; GO = 1'b0; BCODE = 1'b0;
        @(negedge CLK25);
        checks++; if (obs0 !== 12'h7E0) $display("FAIL reset0 got %h want %h", obs0, 12'h7E0); else passes++;
        checks++; if (obs1 !== 12'h7E0) $display("FAIL reset1 got %h want %h", obs1, 12'h7E0); else passes++;
        tick();
        clr_oec = 1'b0;
        repeat (9) begin
            tick();
            checks++; if (obs0 !== 12'h7E0) $display("FAIL idle0 got %h want %h", obs0, 12'h7E0); else passes++;
        end
    endtask

    task automatic test_normal_block();
        logic [5:0] one;
        logic [5:0] want;
        one = 6'b1;
        GO = 1'b1;
        tick();
        checks++; if (START0 !== 1'b1 || BUSY0 !== 1'b1) $display("FAIL start_pulse got %b%b want 11", START0, BUSY0); else passes++;
        GO = 1'b0;
        for (int i = 0; i < 48; i++) begin
            tick();
            want = ~(one << (i % 6));
            checks++; if (OE_B0 !== want || OECRC0 !== (i >= 42) || START0 !== 1'b0) $display("FAIL row_strobe i=%0d got oe=%h crc=%b want oe=%h crc=%b", i, OE_B0, OECRC0, want, i >= 42); else passes++;
            checks++; if (obs1 !== exp_vec(1)) $display("FAIL model1 got %h want %h", obs1, exp_vec(1)); else passes++;
        end
        repeat (TRAIL + 3) begin
            tick();
            checks++; if (OE_B0 !== 6'h3F || BUSY0 !== 1'b1 || DLOAD0 !== 1'b0) $display("FAIL trail_wait got oe=%h busy=%b want 3f 1", OE_B0, BUSY0); else passes++;
        end
        clr_oec = 1'b1;
        #1;
        checks++; if (BUSY0 !== 1'b0 || ERR0 !== 1'b0) $display("FAIL clr_after_trail got busy=%b err=%b want 0 0", BUSY0, ERR0); else passes++;
        tick();
        clr_oec = 1'b0;
        GO = 1'b1;
        tick();
        GO = 1'b0;
        repeat (6 * 8 + TRAIL + 3) begin
            tick();
            checks++; if (obs0 !== exp_vec(0)) $display("FAIL second_block got %h want %h", obs0, exp_vec(0)); else passes++;
        end
        clr_oec = 1'b1; tick(); clr_oec = 1'b0;
    endtask

    task automatic test_bcode();
        GO = 1'b1; BCODE = 1'b0;
        tick();
        GO = 1'b0;
        for (int i = 0; i < 52; i++) begin
            BCODE = (mo[0] == 12);
            tick();
            checks++; if (obs0 !== exp_vec(0)) $display("FAIL bcode_model got %h want %h", obs0, exp_vec(0)); else passes++;
            if (mo[0] >= 13 && mo[0] <= 18) begin
                checks++; if (DLOAD0 !== 1'b1 || OE_B0 !== 6'h3F) $display("FAIL bcode_row2 got dl=%b oe=%h want 1 3f", DLOAD0, OE_B0); else passes++;
            end else if (mo[0] >= 1 && mo[0] <= 48) begin
                checks++; if (DLOAD0 !== 1'b0 || OE_B0 === 6'h3F) $display("FAIL bcode_other got dl=%b oe=%h want 0 onehot", DLOAD0, OE_B0); else passes++;
            end
        end
        BCODE = 1'b0;
        clr_oec = 1'b1; tick(); clr_oec = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        GO = 1'b1;
        tick();
        GO = 1'b0;
        n = 0;
        while (BUSY0 === 1'b1 && n < 300) begin
            tick();
            n++;
            checks++; if (obs0 !== exp_vec(0)) $display("FAIL tmo_model0 got %h want %h", obs0, exp_vec(0)); else passes++;
            checks++; if (obs1 !== exp_vec(1)) $display("FAIL tmo_model1 got %h want %h", obs1, exp_vec(1)); else passes++;
        end
        checks++; if (n !== 6 * 8 + TRAIL + TMO + 1) $display("FAIL tmo_len got %0d want %0d", n, 6 * 8 + TRAIL + TMO + 1); else passes++;
        checks++; if (ERR0 !== 1'b1 || BUSY0 !== 1'b0) $display("FAIL tmo_flag got err=%b busy=%b want 1 0", ERR0, BUSY0); else passes++;
        clr_oec = 1'b1;
        #1;
        checks++; if (ERR0 !== 1'b0) $display("FAIL tmo_clear got %b want 0", ERR0); else passes++;
        tick();
        clr_oec = 1'b0;
    endtask

    task automatic test_go_override();
        GO = 1'b1;
        tick();
        GO = 1'b0;
        repeat (20) begin
            tick();
            checks++; if (obs0 !== exp_vec(0)) $display("FAIL ovr_pre got %h want %h", obs0, exp_vec(0)); else passes++;
        end
        GO = 1'b1;
        tick();
        checks++; if (OVR0 !== 1'b1 || OE_B0 !== 6'h3B) $display("FAIL go_ovr got ovr=%b oe=%h want 1 3b", OVR0, OE_B0); else passes++;
        repeat (120) begin
            tick();
            checks++; if (obs0 !== exp_vec(0)) $display("FAIL ovr_model0 got %h want %h", obs0, exp_vec(0)); else passes++;
            checks++; if (obs1 !== exp_vec(1)) $display("FAIL ovr_model1 got %h want %h", obs1, exp_vec(1)); else passes++;
        end
        checks++; if (BUSY0 !== 1'b0 || START0 !== 1'b0) $display("FAIL go_held got busy=%b start=%b want 0 0", BUSY0, START0); else passes++;
        GO = 1'b0;
        clr_oec = 1'b1; tick(); clr_oec = 1'b0;
    endtask

    task automatic test_abort();
        GO = 1'b1;
        tick();
        GO = 1'b0;
        repeat (27) begin
            tick();
            checks++; if (obs0 !== exp_vec(0)) $display("FAIL abort_pre got %h want %h", obs0, exp_vec(0)); else passes++;
        end
        checks++; if (OE_B0 !== 6'h3B) $display("FAIL abort_pos got %h want 3b", OE_B0); else passes++;
        clr_oec = 1'b1;
        #1;
        checks++; if ({OE_B0, DLOAD0, OECRC0, BUSY0} !== {6'h3F, 3'b000}) $display("FAIL abort_now got oe=%h dl=%b crc=%b busy=%b want 3f 0 0 0", OE_B0, DLOAD0, OECRC0, BUSY0); else passes++;
        tick();
        checks++; if (obs0 !== exp_vec(0)) $display("FAIL abort_hold got %h want %h", obs0, exp_vec(0)); else passes++;
        clr_oec = 1'b0;
        repeat (3) begin
            tick();
            checks++; if (obs0 !== 12'h7E0) $display("FAIL abort_idle got %h want %h", obs0, 12'h7E0); else passes++;
        end
    endtask

    task automatic test_nsamp1();
        GO = 1'b1;
        tick();
        checks++; if (START1 !== 1'b1 || OECRC1 !== 1'b0) $display("FAIL n1_start got start=%b crc=%b want 1 0", START1, OECRC1); else passes++;
        GO = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (OECRC1 !== (i < 6) || START1 !== 1'b0) $display("FAIL n1_oecrc i=%0d got %b want %b", i, OECRC1, i < 6); else passes++;
        end
        clr_oec = 1'b1; tick(); clr_oec = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 59) == 0) GO = ~GO;
            BCODE   = 1'($urandom_range(0, 1));
            clr_oec = ($urandom_range(0, 299) == 0);
            tick();
            checks++; if (obs0 !== exp_vec(0)) $display("FAIL rand0 i=%0d got %h want %h", i, obs0, exp_vec(0)); else passes++;
            checks++; if (obs1 !== exp_vec(1)) $display("FAIL rand1 i=%0d got %h want %h", i, obs1, exp_vec(1)); else passes++;
        end
        clr_oec = 1'b0;
    endtask

    initial begin
        mn[0] = 8; mn[1] = 1;
        mo[0] = -1; mo[1] = -1;
        merr[0] = 1'b0; merr[1] = 1'b0;
        movr[0] = 1'b0; movr[1] = 1'b0;
        mgo1 = 1'b0;
        test_reset();
        test_normal_block();
        test_bcode();
        test_timeout();
        test_go_override();
        test_abort();
        test_nsamp1();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
